mul16_seq: RTL and testbench

- Sequential 16-bit shift-and-add multiplier controller. It time-shares a single instance of the team's 16-bit ripple adder (Add16, carry-out discarded) over successive clock cycles to form the low 16 bits of a*b.
- Serves as the multiply resource for the ALU/CPU layer, which has no combinational multiplier.
- Uses a start/valid/ack handshake toward the requester.

---
 rtl/mul16_seq.sv | 98 +++++++++
 tb/tb_mul16_seq.sv | 114 +++++++++++
 2 files changed

// File: rtl/mul16_seq.sv
// Sequential shift-and-add multiplier: low 16 bits of a*b[ITER-1:0] using one shared add16.
// Optional MUL16_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.

module add16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [15:0] sum
);
  logic [15:0] c;

  assign c[0] = 1'b0;
  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign sum[i] = x[i] ^ y[i] ^ c[i];
    // Carry out of bit 15 is dropped, so no carry is generated for the top bit
    if (i < 15) begin : g_c
      assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end
endmodule

module mul16_seq #(
  parameter int ITER = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        valid,
  input  logic        ack,
  output logic [15:0] product
);
  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [15:0]   acc, mcand, mplier, sum, acc_nx;
  logic [CW-1:0] cnt;
  logic          last;

  add16 u_add (.x(acc), .y(mcand), .sum(sum));

  assign acc_nx = mplier[0] ? sum : acc;

`ifdef MUL16_EARLY_EXIT_EN
  assign last = (cnt == CW'(ITER - 1)) || ((mplier >> 1) == 16'd0);
`else
  assign last = (cnt == CW'(ITER - 1));
`endif

  // product is a registered copy so it survives acc being cleared at the next start
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      valid   <= 1'b0;
      product <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc    <= '0;
          mcand  <= a;
          mplier <= b;
          cnt    <= '0;
          busy   <= 1'b1;
          state  <= RUN;
        end
        RUN: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last) begin
            product <= acc_nx;
            busy    <= 1'b0;
            valid   <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: if (ack) begin
          valid <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul16_seq.sv
// Directed bench for mul16_seq: latency, wrap, signed, ignored inputs, reset mid-op, early exit.
// Expected latencies follow MUL16_EARLY_EXIT_EN when it is defined for the build.

module tb_mul16_seq;
  logic        clock = 1'b0, reset = 1'b1, start = 1'b0, ack = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, valid;
  logic [15:0] product;
  int          errs = 0, checks = 0;
  logic [15:0] last_prod = '0;

  mul16_seq #(.ITER(16)) dut (
    .clock(clock), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .valid(valid), .ack(ack), .product(product)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) chk("excl", {31'd0, busy & valid}, 32'd0);

  task automatic start_op(input logic [15:0] x, input logic [15:0] y);
    start = 1'b1; a = x; b = y;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Called right after the accepting edge; counts edges until valid.
  task automatic wait_done(input string tag, input int lat_ee, input logic [15:0] exp,
                           input bit repulse);
    int n;
    int lat;
    n = 0;
`ifdef MUL16_EARLY_EXIT_EN
    lat = lat_ee;
`else
    lat = 16;
`endif
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_hold"}, {16'd0, product}, {16'd0, last_prod});
    while (!valid && n < 40) begin
      if (repulse && n == 1) begin start = 1'b1; a = 16'd9; b = 16'd9; end
      if (repulse && n == 2) start = 1'b0;
      @(posedge clock); #1;
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_prod"}, {16'd0, product}, {16'd0, exp});
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    last_prod = exp;
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    @(posedge clock); #1;
    ack = 1'b0;
    chk({tag, "_ackv"}, {31'd0, valid}, 32'd0);
    chk({tag, "_keep"}, {16'd0, product}, {16'd0, last_prod});
  endtask

  initial begin
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_prod", {16'd0, product}, 32'd0);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;

    start_op(16'd3, 16'd5);         wait_done("basic", 3, 16'h000F, 1'b0); do_ack("basic");
    start_op(16'hFFFF, 16'hFFFF);   wait_done("wrap1", 16, 16'h0001, 1'b0); do_ack("wrap1");
    start_op(16'h0100, 16'h0100);   wait_done("wrap0", 9, 16'h0000, 1'b0); do_ack("wrap0");
    start_op(16'hFFFD, 16'h0007);   wait_done("signed", 3, 16'hFFEB, 1'b0); do_ack("signed");
    start_op(16'd3, 16'd5);         wait_done("repulse", 3, 16'h000F, 1'b0 | 1'b1); do_ack("repulse");

    // ack and start together in DONE: back to IDLE only, then held start is accepted
    start_op(16'd2, 16'd3);         wait_done("pre_as", 2, 16'h0006, 1'b0);
    ack = 1'b1; start = 1'b1; a = 16'd5; b = 16'd6;
    @(posedge clock); #1;
    ack = 1'b0;
    chk("as_valid", {31'd0, valid}, 32'd0);
    chk("as_busy", {31'd0, busy}, 32'd0);
    @(posedge clock); #1;
    start = 1'b0;
    wait_done("as_run", 3, 16'h001E, 1'b0); do_ack("as_run");

    // reset in the middle of a run
    start_op(16'd3, 16'hFFFF);
    repeat (6) begin @(posedge clock); #1; end
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1; #1;
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_valid", {31'd0, valid}, 32'd0);
    chk("mr_prod", {16'd0, product}, 32'd0);
    last_prod = '0;
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    start_op(16'd2, 16'd2);         wait_done("after_rst", 2, 16'h0004, 1'b0); do_ack("after_rst");

    start_op(16'd7, 16'h0001);      wait_done("ee_b1", 1, 16'h0007, 1'b0); do_ack("ee_b1");
    start_op(16'd7, 16'h0004);      wait_done("ee_b4", 3, 16'h001C, 1'b0); do_ack("ee_b4");
    start_op(16'd7, 16'h8000);      wait_done("ee_b8000", 16, 16'h8000, 1'b0); do_ack("ee_b8000");
    start_op(16'd7, 16'h0000);      wait_done("ee_b0", 1, 16'h0000, 1'b0); do_ack("ee_b0");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
